// File: rtl/fht_result_reader_if.sv
// Bundle of read-out handshake, bank address and bank data signals of the
// FHT result reader. The reader takes the slave view; whoever starts the
// read-out, owns the banks and consumes the stream takes the master view.
interface fht_result_reader_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
);
    logic                    iSTART;
    logic [A_BIT-1:0]        oADDR_RD_0;
    logic [A_BIT-1:0]        oADDR_RD_1;
    logic [A_BIT-1:0]        oADDR_RD_2;
    logic [A_BIT-1:0]        oADDR_RD_3;
    logic signed [D_BIT-1:0] iDATA_0;
    logic signed [D_BIT-1:0] iDATA_1;
    logic signed [D_BIT-1:0] iDATA_2;
    logic signed [D_BIT-1:0] iDATA_3;
    logic signed [D_BIT-1:0] oDATA;
    logic [A_BIT+1:0]        oIDX;
    logic                    oVALID;
    logic                    iREADY;
    logic                    oLAST;
    logic                    oBUSY;
    logic                    oDONE;

    modport slave (
        input  iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        output oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
    );

    modport master (
        output iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
        input  oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3,
               oDATA, oIDX, oVALID, oLAST, oBUSY, oDONE
    );
endinterface

// File: rtl/fht_result_reader.sv
// FHT result read-out engine: walks k = 0..N-1, reads the four banks with a
// shared address, picks the bank holding sample k, and streams the samples
// in natural order through a small show-ahead FIFO with valid/ready.
module fht_result_reader #(
    parameter int N           = 1024,
    parameter int BANK_SIZE   = N / 4,
    parameter int A_BIT       = $clog2(BANK_SIZE),
    parameter int D_BIT       = 16,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int BANK_BITREV = 1
) (
    input logic iCLK,
    input logic iRESET,
    fht_result_reader_if.slave bus
);
    localparam int KW = A_BIT + 3;
    localparam int IW = A_BIT + 2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [KW-1:0]           ki;
    logic [A_BIT-1:0]        addr_q;
    logic                    busy_q;
    logic                    done_q;

    logic [RD_LAT-1:0]       pipe_vld;
    logic [1:0]              pipe_bank [RD_LAT];
    logic [IW-1:0]           pipe_idx  [RD_LAT];

    logic signed [D_BIT-1:0] fifo_data [FIFO_DEPTH];
    logic [IW-1:0]           fifo_idx  [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [CW-1:0]           count;

    logic [KW-1:0]           issue_k;
    logic [1:0]              issue_bank;
    logic [OW-1:0]           inflight;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    head_valid;
    logic [IW-1:0]           head_idx;
    logic signed [D_BIT-1:0] cap_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Issue decision, bank selection and capture mux. The iSTART cycle
    // itself issues k=0, so the DUT address register is the first stage of
    // the RD_LAT bank latency.
    always_comb begin
        issue_k = (state == IDLE) ? '0 : ki;
        if (BANK_BITREV != 0)
            issue_bank = {issue_k[A_BIT], issue_k[A_BIT+1]};
        else
            issue_bank = issue_k[A_BIT+1:A_BIT];
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++)
            inflight = inflight + OW'(pipe_vld[i]);
        issue = ((state == RUN) || (state == IDLE && bus.iSTART))
                && (issue_k < KW'(N))
                && ((OW'(count) + inflight) < OW'(FIFO_DEPTH));
        head_valid = (count != '0);
        head_idx   = fifo_idx[rd_ptr];
        push       = pipe_vld[RD_LAT-1];
        pop        = head_valid && bus.iREADY;
        case (pipe_bank[RD_LAT-1])
            2'd0:    cap_data = bus.iDATA_0;
            2'd1:    cap_data = bus.iDATA_1;
            2'd2:    cap_data = bus.iDATA_2;
            default: cap_data = bus.iDATA_3;
        endcase
    end

    // Control: FSM, issue counter, in-flight valids and FIFO pointers/count.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state    <= IDLE;
            ki       <= '0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pipe_vld <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int unsigned i = 1; i < RD_LAT; i++)
                pipe_vld[i] <= pipe_vld[i-1];
            if (issue) begin
                addr_q <= issue_k[A_BIT-1:0];
                ki     <= issue_k + KW'(1);
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            case (state)
                IDLE: begin
                    if (bus.iSTART) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (pop && head_idx == IW'(N - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline and FIFO storage; validity is tracked in the control block.
    always_ff @(posedge iCLK) begin
        pipe_bank[0] <= issue_bank;
        pipe_idx[0]  <= issue_k[IW-1:0];
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_bank[i] <= pipe_bank[i-1];
            pipe_idx[i]  <= pipe_idx[i-1];
        end
        if (push) begin
            fifo_data[wr_ptr] <= cap_data;
            fifo_idx[wr_ptr]  <= pipe_idx[RD_LAT-1];
        end
    end

    assign bus.oADDR_RD_0 = addr_q;
    assign bus.oADDR_RD_1 = addr_q;
    assign bus.oADDR_RD_2 = addr_q;
    assign bus.oADDR_RD_3 = addr_q;
    assign bus.oVALID     = head_valid;
    assign bus.oDATA      = head_valid ? fifo_data[rd_ptr] : '0;
    assign bus.oIDX       = head_valid ? head_idx : '0;
    assign bus.oLAST      = head_valid && (head_idx == IW'(N - 1));
    assign bus.oBUSY      = busy_q;
    assign bus.oDONE      = done_q;
endmodule

// File: tb/tb_fht_result_reader.sv
// Bench for fht_result_reader: two readers (bank bit-reversal on and off)
// run in lockstep against bank models returning bank*1000+addr; the stream
// is checked against the natural-order sample rule.
`timescale 1ns/1ps
module tb_fht_result_reader;
    localparam int N          = 1024;
    localparam int BANK_SIZE  = 256;
    localparam int A_BIT      = 8;
    localparam int D_BIT      = 16;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b0;

    always #5 clk = ~clk;

    fht_result_reader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) f1 ();
    fht_result_reader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) f0 ();

    assign f1.iSTART = start;
    assign f0.iSTART = start;
    assign f1.iREADY = ready;
    assign f0.iREADY = ready;

    // Bank model: the reader's address register is the first latency cycle,
    // one more register here makes a 2-cycle bank.
    logic [A_BIT-1:0] r1 [4];
    logic [A_BIT-1:0] r0 [4];
    always @(posedge clk) begin
        r1[0] <= f1.oADDR_RD_0; r1[1] <= f1.oADDR_RD_1;
        r1[2] <= f1.oADDR_RD_2; r1[3] <= f1.oADDR_RD_3;
        r0[0] <= f0.oADDR_RD_0; r0[1] <= f0.oADDR_RD_1;
        r0[2] <= f0.oADDR_RD_2; r0[3] <= f0.oADDR_RD_3;
    end
    assign f1.iDATA_0 = D_BIT'(0    + int'(r1[0]));
    assign f1.iDATA_1 = D_BIT'(1000 + int'(r1[1]));
    assign f1.iDATA_2 = D_BIT'(2000 + int'(r1[2]));
    assign f1.iDATA_3 = D_BIT'(3000 + int'(r1[3]));
    assign f0.iDATA_0 = D_BIT'(0    + int'(r0[0]));
    assign f0.iDATA_1 = D_BIT'(1000 + int'(r0[1]));
    assign f0.iDATA_2 = D_BIT'(2000 + int'(r0[2]));
    assign f0.iDATA_3 = D_BIT'(3000 + int'(r0[3]));

    fht_result_reader #(.N(N), .BANK_SIZE(BANK_SIZE), .A_BIT(A_BIT), .D_BIT(D_BIT),
                        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .BANK_BITREV(1))
        dut1 (.iCLK(clk), .iRESET(rst), .bus(f1));
    fht_result_reader #(.N(N), .BANK_SIZE(BANK_SIZE), .A_BIT(A_BIT), .D_BIT(D_BIT),
                        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .BANK_BITREV(0))
        dut0 (.iCLK(clk), .iRESET(rst), .bus(f0));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Natural index k lives in bank k/BANK_SIZE (2-bit reversed if asked) at address k%BANK_SIZE.
    function automatic int exp_data(input int k, input int bitrev);
        int q;
        int bank;
        q = k / BANK_SIZE;
        bank = (bitrev != 0) ? ((q % 2) * 2 + q / 2) : q;
        return bank * 1000 + k % BANK_SIZE;
    endfunction

    // Scoreboard state
    int exp_k = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    bit exp_done = 1'b0;
    bit rst_seen = 1'b0;
    bit contig = 1'b0;
    logic p_valid = 1'b0;
    logic p_ready = 1'b0;
    logic signed [D_BIT-1:0] p_data = '0;
    logic [A_BIT+1:0] p_idx = '0;

    task automatic check_reset_vals();
        check_val("rst_data", f1.oDATA, 0);
        check_val("rst_idx", f1.oIDX, 0);
        check_val("rst_valid", f1.oVALID, 0);
        check_val("rst_last", f1.oLAST, 0);
        check_val("rst_busy", f1.oBUSY, 0);
        check_val("rst_done", f1.oDONE, 0);
        check_val("rst_addr0", f1.oADDR_RD_0, 0);
        check_val("rst_addr3", f1.oADDR_RD_3, 0);
        check_val("rst_valid_b0", f0.oVALID, 0);
        check_val("rst_busy_b0", f0.oBUSY, 0);
    endtask

    always @(negedge clk) begin
        int diff;
        if (rst) begin
            rst_seen = 1'b1;
            exp_k = 0;
            exp_done = 1'b0;
            p_valid = 1'b0;
        end else begin
            if (rst_seen) begin
                check_reset_vals();
                rst_seen = 1'b0;
            end
            check_val("done_pulse", f1.oDONE, exp_done);
            check_val("done_pulse_b0", f0.oDONE, exp_done);
            exp_done = 1'b0;
            if (f1.oDONE) done_cnt++;
            check_val("lockstep_valid", f0.oVALID, f1.oVALID);
            if (p_valid && !p_ready) begin
                check_val("held_valid", f1.oVALID, 1);
                check_val("held_data", f1.oDATA, p_data);
                check_val("held_idx", f1.oIDX, p_idx);
            end
            if (f1.oVALID && ready) begin
                check_val("idx", f1.oIDX, exp_k);
                check_val("data_bitrev", f1.oDATA, exp_data(exp_k, 1));
                check_val("idx_b0", f0.oIDX, exp_k);
                check_val("data_b0", f0.oDATA, exp_data(exp_k, 0));
                check_val("last", f1.oLAST, (exp_k == N - 1) ? 1 : 0);
                if (exp_k == N - 1) exp_done = 1'b1;
                exp_k++;
                hs_cnt++;
            end else if (contig && exp_k > 0 && exp_k < N) begin
                check_val("gap", f1.oVALID & ready, 1);
            end
            if (!f1.oVALID) check_val("last_idle", f1.oLAST, 0);
            diff = ((int'(f1.oADDR_RD_0) + 1 - exp_k) % BANK_SIZE + BANK_SIZE) % BANK_SIZE;
            check_val("outstanding", (diff <= FIFO_DEPTH) ? 1 : 0, 1);
            p_valid = f1.oVALID;
            p_ready = ready;
            p_data  = f1.oDATA;
            p_idx   = f1.oIDX;
        end
    end

    // Downstream ready generator
    int mode = 0;
    int cyc = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       ready = ($urandom_range(0, 3) != 0);
                default: ready = 1'b0;
            endcase
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_val("busy_after_start", f1.oBUSY, 1);
        check_val("lat_c1_valid", f1.oVALID, 0);
        @(negedge clk);
        check_val("lat_c2_valid", f1.oVALID, 0);
        @(negedge clk);
        check_val("lat_c3_valid", f1.oVALID, 1);
        check_val("lat_c3_idx", f1.oIDX, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit noisy);
        int c0;
        int t;
        c0 = done_cnt;
        t = 0;
        while (done_cnt == c0 && t < budget) begin
            start = noisy && f1.oBUSY && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        check_val({tag, "_done_seen"}, (done_cnt != c0) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, "_single_done"}, done_cnt - c0, 1);
        check_val({tag, "_handshakes"}, hs_cnt, N);
        check_val({tag, "_busy_end"}, f1.oBUSY, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full-rate streaming
        mode = 0; contig = 1'b1; exp_k = 0; hs_cnt = 0;
        pulse_start();
        wait_done("full_rate", 3000, 1'b0);

        // Ready pattern 1,0,0,1
        mode = 1; contig = 1'b0; exp_k = 0; hs_cnt = 0;
        pulse_start();
        wait_done("toggle", 6000, 1'b0);

        // Downstream blocked for 50 cycles, then released
        mode = 3; contig = 1'b0; exp_k = 0; hs_cnt = 0;
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        check_val("stall_addr0", f1.oADDR_RD_0, FIFO_DEPTH - 1);
        check_val("stall_addr1", f1.oADDR_RD_1, FIFO_DEPTH - 1);
        check_val("stall_addr2", f1.oADDR_RD_2, FIFO_DEPTH - 1);
        check_val("stall_addr3", f1.oADDR_RD_3, FIFO_DEPTH - 1);
        check_val("stall_addr_b0", f0.oADDR_RD_0, FIFO_DEPTH - 1);
        check_val("stall_handshakes", hs_cnt, 0);
        check_val("stall_valid", f1.oVALID, 1);
        check_val("stall_idx", f1.oIDX, 0);
        mode = 0; contig = 1'b1;
        wait_done("stall_release", 3000, 1'b0);

        // Random ready, reset at k=300
        mode = 2; contig = 1'b0; exp_k = 0; hs_cnt = 0;
        begin
            int c0;
            int t;
            c0 = done_cnt;
            pulse_start();
            t = 0;
            while (exp_k < 300 && t < 2000) begin
                @(posedge clk); #1;
                t++;
            end
            check_val("reach_k300", (exp_k >= 300) ? 1 : 0, 1);
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            check_val("no_done_after_reset", done_cnt - c0, 0);
            check_val("idle_after_reset_valid", f1.oVALID, 0);
            check_val("idle_after_reset_busy", f1.oBUSY, 0);
        end

        // Restart from k=0 with stray iSTART pulses while busy
        mode = 0; contig = 1'b1; exp_k = 0; hs_cnt = 0;
        pulse_start();
        wait_done("restart_noisy", 3000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog");
    end
endmodule
